// File: rtl/fifo_share_pkg.sv
// fifo_share_pkg: arbiter states, owner encodings and default sizes for the shared-FIFO controller
package fifo_share_pkg;
  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;
  localparam logic [1:0] OWNER_NONE = 2'b00;
  localparam logic [1:0] OWNER_P0 = 2'b01;
  localparam logic [1:0] OWNER_P1 = 2'b10;
  localparam int DW_DEF = 8;
  localparam int BURST_MAX_DEF = 4;
endpackage

// File: rtl/fifo_share_rdbuf.sv
// fifo_share_rdbuf: read sequencer hiding the FIFO's registered read latency behind a 2-entry buffer
module fifo_share_rdbuf
  import fifo_share_pkg::*;
#(
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic          fifo_read_req,
  input  logic [DW-1:0] fifo_read_data,
  input  logic          fifo_empty,
  output logic          m_valid,
  output logic [DW-1:0] m_data,
  input  logic          m_ready
);
  logic [DW-1:0] mem [2];
  logic [1:0] cnt;
  logic inflight, wr_ptr, rd_ptr, pop;
  assign pop = m_valid & m_ready;
  // a read is only issued when its data is guaranteed a free slot on arrival
  assign fifo_read_req = ~fifo_empty & (({1'b0, cnt} + {2'b0, inflight}) < (3'd2 + {2'b0, pop}));
  assign m_valid = cnt != 2'd0;
  assign m_data = mem[rd_ptr];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      cnt <= '0;
      inflight <= 1'b0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      inflight <= fifo_read_req;
      if (inflight) begin
        mem[wr_ptr] <= fifo_read_data;
        wr_ptr <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      cnt <= cnt + {1'b0, inflight} - {1'b0, pop};
    end
endmodule

// File: rtl/fifo_share_ctrl.sv
// fifo_share_ctrl: shares one sync FIFO between two writers (round-robin, bounded bursts) and streams it out.
// Define FIFO_SHARE_STATS_EN to add saturating grant and full-stall counters.
module fifo_share_ctrl
  import fifo_share_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int BURST_MAX = BURST_MAX_DEF,
  parameter int CNT_W = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          p0_valid,
  input  logic [DW-1:0] p0_data,
  output logic          p0_ready,
  input  logic          p1_valid,
  input  logic [DW-1:0] p1_data,
  output logic          p1_ready,
  output logic          fifo_write_req,
  output logic [DW-1:0] fifo_write_data,
  input  logic          fifo_full,
  output logic          fifo_read_req,
  input  logic [DW-1:0] fifo_read_data,
  input  logic          fifo_empty,
  output logic          m_valid,
  output logic [DW-1:0] m_data,
  input  logic          m_ready,
  output logic [1:0]    owner
`ifdef FIFO_SHARE_STATS_EN
  ,
  output logic [CNT_W-1:0] grant_cnt0,
  output logic [CNT_W-1:0] grant_cnt1,
  output logic [CNT_W-1:0] full_stall_cnt
`endif
);
  localparam int BW = BURST_MAX > 1 ? $clog2(BURST_MAX) : 1;
  if (BURST_MAX < 1 || CNT_W < 1) begin : g_param_check
    $error("fifo_share_ctrl: BURST_MAX and CNT_W must be >= 1");
  end
  state_t state;
  logic rr;
  logic [BW-1:0] beat_cnt;
  logic cur_valid, oth_valid, acc, trig;
  assign cur_valid = state == OWN0 ? p0_valid : state == OWN1 ? p1_valid : 1'b0;
  assign oth_valid = state == OWN0 ? p1_valid : p0_valid;
  assign acc = cur_valid & ~fifo_full;
  assign p0_ready = (state == OWN0) & p0_valid & ~fifo_full;
  assign p1_ready = (state == OWN1) & p1_valid & ~fifo_full;
  assign fifo_write_req = acc;
  assign fifo_write_data = state == OWN1 ? p1_data : p0_data;
  assign owner = state == OWN0 ? OWNER_P0 : state == OWN1 ? OWNER_P1 : OWNER_NONE;
  // a burst ends when the owner drops valid or its last allowed beat is accepted
  assign trig = ~cur_valid | (acc & (beat_cnt == BW'(BURST_MAX - 1)));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      rr <= 1'b0;
      beat_cnt <= '0;
    end else if (state == IDLE) begin
      if (p0_valid & p1_valid) state <= rr ? OWN1 : OWN0;
      else if (p0_valid) state <= OWN0;
      else if (p1_valid) state <= OWN1;
    end else if (trig) begin
      beat_cnt <= '0;
      rr <= state == OWN0;
      state <= oth_valid ? (state == OWN0 ? OWN1 : OWN0) : cur_valid ? state : IDLE;
    end else if (acc) begin
      beat_cnt <= beat_cnt + 1'b1;
    end
`ifdef FIFO_SHARE_STATS_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      grant_cnt0 <= '0;
      grant_cnt1 <= '0;
      full_stall_cnt <= '0;
    end else begin
      if (p0_ready & ~&grant_cnt0) grant_cnt0 <= grant_cnt0 + 1'b1;
      if (p1_ready & ~&grant_cnt1) grant_cnt1 <= grant_cnt1 + 1'b1;
      if (cur_valid & fifo_full & ~&full_stall_cnt) full_stall_cnt <= full_stall_cnt + 1'b1;
    end
`endif
  fifo_share_rdbuf #(.DW(DW)) u_rdbuf (
    .clk(clk),
    .rst_n(rst_n),
    .fifo_read_req(fifo_read_req),
    .fifo_read_data(fifo_read_data),
    .fifo_empty(fifo_empty),
    .m_valid(m_valid),
    .m_data(m_data),
    .m_ready(m_ready)
  );
endmodule

// File: tb/tb_fifo_share_ctrl.sv
// tb_fifo_share_ctrl: drives fifo_share_ctrl against a 16-deep FIFO model with a data scoreboard
module tb_fifo_share_ctrl;
  localparam int BM = 4;
  localparam int DEPTH = 16;
  logic clk = 0, rst_n = 0;
  logic p0_valid = 0, p1_valid = 0, m_ready = 0;
  logic [7:0] p0_data = 0, p1_data = 0;
  logic p0_ready, p1_ready, fifo_write_req, fifo_full, fifo_read_req, fifo_empty, m_valid;
  logic [7:0] fifo_write_data, fifo_read_data, m_data;
  logic [1:0] owner;
  int errors = 0, checks = 0;
  always #5 clk = ~clk;

  fifo_share_ctrl #(.DW(8), .BURST_MAX(BM), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .p0_valid(p0_valid), .p0_data(p0_data), .p0_ready(p0_ready),
    .p1_valid(p1_valid), .p1_data(p1_data), .p1_ready(p1_ready),
    .fifo_write_req(fifo_write_req), .fifo_write_data(fifo_write_data), .fifo_full(fifo_full),
    .fifo_read_req(fifo_read_req), .fifo_read_data(fifo_read_data), .fifo_empty(fifo_empty),
    .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready), .owner(owner)
  );

  // sync FIFO with registered read data, reset by the same rst_n
  logic [7:0] fmem [DEPTH];
  logic [7:0] frd;
  int fcnt = 0, fwp = 0, frp = 0;
  assign fifo_full = fcnt == DEPTH;
  assign fifo_empty = fcnt == 0;
  assign fifo_read_data = frd;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      fcnt <= 0; fwp <= 0; frp <= 0; frd <= 0;
    end else begin
      if (fifo_read_req && fcnt > 0) begin frd <= fmem[frp]; frp <= (frp + 1) % DEPTH; end
      if (fifo_write_req && fcnt < DEPTH) begin fmem[fwp] <= fifo_write_data; fwp <= (fwp + 1) % DEPTH; end
      fcnt <= fcnt + int'(fifo_write_req && fcnt < DEPTH) - int'(fifo_read_req && fcnt > 0);
    end

  // scoreboard: accepted beats in order, popped by the output stream
  logic [7:0] exp_q[$];
  logic a0, a1, stall_prev = 0;
  logic [7:0] data_prev = 0;
  int s0 = 0, s1 = 0, pops = 0;
  always @(negedge clk)
    if (!rst_n) begin
      exp_q.delete(); s0 = 0; s1 = 0; stall_prev = 0;
    end else begin
      a0 = p0_valid & p0_ready;
      a1 = p1_valid & p1_ready;
      checks++;
      if ((a0 && a1) || fifo_write_req !== (a0 | a1)) begin
        errors++; $display("FAIL wr_handshake: write_req=%0b p0_acc=%0b p1_acc=%0b, required exactly one accept per write", fifo_write_req, a0, a1);
      end
      if (a0 | a1) begin
        checks++;
        if (fifo_write_data !== (a0 ? p0_data : p1_data)) begin
          errors++; $display("FAIL wr_data: got %02h required %02h", fifo_write_data, a0 ? p0_data : p1_data);
        end
        exp_q.push_back(a0 ? p0_data : p1_data);
      end
      checks++;
      if ((fifo_write_req && fifo_full) || (fifo_read_req && fifo_empty)) begin
        errors++; $display("FAIL fifo_guard: wr=%0b full=%0b rd=%0b empty=%0b", fifo_write_req, fifo_full, fifo_read_req, fifo_empty);
      end
      if (stall_prev) begin
        checks++;
        if (m_valid !== 1'b1 || m_data !== data_prev) begin
          errors++; $display("FAIL out_hold: m_valid=%0b m_data=%02h required 1/%02h", m_valid, m_data, data_prev);
        end
      end
      if (m_valid && m_ready) begin
        checks++;
        pops++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL out_extra: m_data=%02h with nothing expected", m_data);
        end else begin
          if (m_data !== exp_q[0]) begin
            errors++; $display("FAIL out_data: got %02h required %02h", m_data, exp_q[0]);
          end
          void'(exp_q.pop_front());
        end
      end
      if (!p1_valid) s0 = 0;
      if (!p0_valid) s1 = 0;
      if (a0) begin if (p1_valid) s0++; s1 = 0; end
      if (a1) begin if (p0_valid) s1++; s0 = 0; end
      checks++;
      if (s0 > BM || s1 > BM) begin
        errors++; $display("FAIL burst_len: p0 run=%0d p1 run=%0d while other waits, required <= %0d", s0, s1, BM);
      end
      stall_prev = m_valid & ~m_ready;
      data_prev = m_data;
    end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  function automatic bit idle_now();
    return !m_valid && fifo_empty && exp_q.size() == 0 && owner == 2'b00;
  endfunction

  task automatic drain_idle();
    int n = 0;
    m_ready = 1; p0_valid = 0; p1_valid = 0;
    while (n < 200 && !idle_now()) begin tick(); n++; end
    tick(); tick();
    checks++;
    if (!idle_now()) begin
      errors++; $display("FAIL drain: m_valid=%0b fifo_empty=%0b pending=%0d owner=%b, required idle", m_valid, fifo_empty, exp_q.size(), owner);
    end
  endtask

  task automatic test_reset();
    rst_n = 0; p0_valid = 1; p1_valid = 1; m_ready = 1;
    repeat (2) tick();
    checks++;
    if ({p0_ready, p1_ready, fifo_write_req, fifo_read_req, m_valid} !== 5'b0) begin
      errors++; $display("FAIL reset_ctl: ready/req/valid=%b required 00000", {p0_ready, p1_ready, fifo_write_req, fifo_read_req, m_valid});
    end
    checks++;
    if (m_data !== 8'h00 || owner !== 2'b00) begin
      errors++; $display("FAIL reset_out: m_data=%02h owner=%b required 00/00", m_data, owner);
    end
    p0_valid = 0; p1_valid = 0;
    @(negedge clk) rst_n = 1;
    tick();
    checks++;
    if (owner !== 2'b00) begin
      errors++; $display("FAIL reset_idle: owner=%b required 00", owner);
    end
  endtask

  task automatic test_single_p0();
    logic [7:0] e;
    m_ready = 1; p0_data = 8'h05; p0_valid = 1; #1;
    checks++;
    if (owner !== 2'b00 || p0_ready !== 1'b0) begin
      errors++; $display("FAIL p0_entry: owner=%b p0_ready=%0b required 00/0", owner, p0_ready);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      e = 8'h05 + 8'(i);
      p0_data = e; #1;
      checks++;
      if (owner !== 2'b01 || fifo_write_req !== 1'b1 || fifo_write_data !== e) begin
        errors++; $display("FAIL p0_beat%0d: owner=%b wr=%0b data=%02h required 01/1/%02h", i, owner, fifo_write_req, fifo_write_data, e);
      end
    end
    tick(); p0_valid = 0;
    tick();
    p0_valid = 1; p1_valid = 1; p0_data = 8'h0a; p1_data = 8'h0b;
    tick(); #1;
    checks++;
    if (owner !== 2'b10 || p1_ready !== 1'b1) begin
      errors++; $display("FAIL rr_after_p0: owner=%b p1_ready=%0b required 10/1", owner, p1_ready);
    end
    tick(); p0_valid = 0; p1_valid = 0;
  endtask

  task automatic test_round_robin();
    int n0 = 0, n1 = 0, g, ex;
    p0_valid = 1; p1_valid = 1;
    for (int i = 0; i < 13; i++) begin
      p0_data = 8'h40 + 8'(n0); p1_data = 8'h80 + 8'(n1); #1;
      g = p0_ready ? 0 : (p1_ready ? 1 : 2);
      ex = i == 0 ? 2 : ((i - 1) / BM) % 2;
      checks++;
      if (g != ex) begin
        errors++; $display("FAIL rr_slot%0d: winner=%0d required %0d (2=none)", i, g, ex);
      end
      if (g == 0) n0++;
      if (g == 1) n1++;
      tick();
    end
    p0_valid = 0; p1_valid = 0;
  endtask

  task automatic test_preload();
    m_ready = 1; p0_valid = 1; p0_data = 8'h64;
    tick();
    tick(); p0_data = 8'h21; #1;
    checks++;
    if (fifo_empty !== 1'b0 || m_valid !== 1'b0) begin
      errors++; $display("FAIL lat0: fifo_empty=%0b m_valid=%0b required 0/0", fifo_empty, m_valid);
    end
    tick(); p0_data = 8'h63; #1;
    checks++;
    if (m_valid !== 1'b0) begin
      errors++; $display("FAIL lat1: m_valid=%0b required 0", m_valid);
    end
    tick(); p0_valid = 0; #1;
    checks++;
    if (m_valid !== 1'b1 || m_data !== 8'h64) begin
      errors++; $display("FAIL first_word: m_valid=%0b m_data=%02h required 1/64", m_valid, m_data);
    end
    tick();
    checks++;
    if (m_valid !== 1'b1 || m_data !== 8'h21) begin
      errors++; $display("FAIL second_word: m_valid=%0b m_data=%02h required 1/21", m_valid, m_data);
    end
    tick();
    checks++;
    if (m_valid !== 1'b1 || m_data !== 8'h63) begin
      errors++; $display("FAIL third_word: m_valid=%0b m_data=%02h required 1/63", m_valid, m_data);
    end
    tick();
    checks++;
    if (m_valid !== 1'b0 || fifo_empty !== 1'b1 || fifo_read_req !== 1'b0) begin
      errors++; $display("FAIL preload_end: m_valid=%0b empty=%0b rd=%0b required 0/1/0", m_valid, fifo_empty, fifo_read_req);
    end
  endtask

  task automatic test_full();
    int n1 = 0, full_seen = 0;
    m_ready = 0; p1_valid = 1;
    for (int i = 0; i < 60 && full_seen < 4; i++) begin
      p1_data = 8'h21 + 8'(n1); #1;
      if (p1_ready) n1++;
      if (fifo_full) full_seen++;
      tick();
    end
    #1;
    checks++;
    if (fifo_full !== 1'b1 || p1_ready !== 1'b0 || fifo_write_req !== 1'b0) begin
      errors++; $display("FAIL full_stall: full=%0b p1_ready=%0b wr=%0b required 1/0/0", fifo_full, p1_ready, fifo_write_req);
    end
    checks++;
    if (owner !== 2'b10) begin
      errors++; $display("FAIL full_owner: owner=%b required 10", owner);
    end
    // 16 held by the FIFO plus 2 parked in the output buffer
    checks++;
    if (n1 != DEPTH + 2) begin
      errors++; $display("FAIL full_count: accepted %0d required %0d", n1, DEPTH + 2);
    end
    checks++;
    if (m_valid !== 1'b1 || m_data !== 8'h21) begin
      errors++; $display("FAIL full_head: m_valid=%0b m_data=%02h required 1/21", m_valid, m_data);
    end
  endtask

  task automatic test_drain();
    int n = 0, p = pops;
    p1_valid = 0;
    while (n < 300 && exp_q.size() != 0) begin
      m_ready = 1'($urandom_range(0, 1));
      tick(); n++;
    end
    checks++;
    if (exp_q.size() != 0 || pops - p != DEPTH + 2) begin
      errors++; $display("FAIL drain_count: popped %0d pending %0d required %0d/0", pops - p, exp_q.size(), DEPTH + 2);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      p0_valid = ($urandom % 4) != 0;
      p1_valid = ($urandom % 4) != 0;
      p0_data = 8'($urandom);
      p1_data = 8'($urandom);
      m_ready = ((i / 100) % 2) != 0 ? ($urandom % 4) == 0 : ($urandom % 4) != 0;
      tick();
    end
  endtask

  task automatic test_reset_mid();
    m_ready = 1; p0_valid = 1; p1_valid = 1; p0_data = 8'h71; p1_data = 8'h72;
    repeat (6) tick();
    checks++;
    if (fifo_read_req !== 1'b1) begin
      errors++; $display("FAIL pre_reset_rd: fifo_read_req=%0b required 1", fifo_read_req);
    end
    #2 rst_n = 0; #1;
    checks++;
    if ({p0_ready, p1_ready, fifo_write_req, fifo_read_req, m_valid} !== 5'b0 || m_data !== 8'h00 || owner !== 2'b00) begin
      errors++; $display("FAIL mid_reset: ctl=%b m_data=%02h owner=%b required 00000/00/00", {p0_ready, p1_ready, fifo_write_req, fifo_read_req, m_valid}, m_data, owner);
    end
    repeat (2) tick();
    @(negedge clk) rst_n = 1;
    tick();
    checks++;
    if (owner !== 2'b01 || p0_ready !== 1'b1 || p1_ready !== 1'b0) begin
      errors++; $display("FAIL post_reset_winner: owner=%b p0_ready=%0b p1_ready=%0b required 01/1/0", owner, p0_ready, p1_ready);
    end
  endtask

  initial begin
    test_reset();
    drain_idle(); test_single_p0();
    drain_idle(); test_round_robin();
    drain_idle(); test_preload();
    drain_idle(); test_full();
    test_drain();
    drain_idle(); test_random();
    drain_idle(); test_reset_mid();
    drain_idle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
